mem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction cache and the data cache. Each cycle it forwards at most one request to memory and returns the memory's accept tag to the winning requester in the same cycle. It records which requester owns each outstanding transaction tag, so the returning data and tag reach the correct cache. It sits between `icache`/`dcache` and the memory model, and replaces the direct `proc2Imem_*` hookup.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arb_tag_table.sv | 43 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

  localparam int DATA_W       = 64;
  localparam int TAG_W        = 4;
  localparam int ARB_NUM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between icache, dcache, memory and the arbiter; slave is the arbiter's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [1:0]        icache2arb_command;
  logic [DATA_W-1:0] icache2arb_addr;
  logic [1:0]        dcache2arb_command;
  logic [DATA_W-1:0] dcache2arb_addr;
  logic [DATA_W-1:0] dcache2arb_data;
  logic [TAG_W-1:0]  mem2arb_response;
  logic [DATA_W-1:0] mem2arb_data;
  logic [TAG_W-1:0]  mem2arb_tag;
  logic [1:0]        arb2mem_command;
  logic [DATA_W-1:0] arb2mem_addr;
  logic [DATA_W-1:0] arb2mem_data;
  logic [TAG_W-1:0]  arb2icache_response;
  logic [DATA_W-1:0] arb2icache_data;
  logic [TAG_W-1:0]  arb2icache_tag;
  logic [TAG_W-1:0]  arb2dcache_response;
  logic [DATA_W-1:0] arb2dcache_data;
  logic [TAG_W-1:0]  arb2dcache_tag;

  modport slave (
    input  icache2arb_command, icache2arb_addr,
    input  dcache2arb_command, dcache2arb_addr, dcache2arb_data,
    input  mem2arb_response, mem2arb_data, mem2arb_tag,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output arb2icache_response, arb2icache_data, arb2icache_tag,
    output arb2dcache_response, arb2dcache_data, arb2dcache_tag
  );

  modport master (
    output icache2arb_command, icache2arb_addr,
    output dcache2arb_command, dcache2arb_addr, dcache2arb_data,
    output mem2arb_response, mem2arb_data, mem2arb_tag,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  arb2icache_response, arb2icache_data, arb2icache_tag,
    input  arb2dcache_response, arb2dcache_data, arb2dcache_tag
  );

endinterface

// File: rtl/mem_arb_tag_table.sv
// Per-tag ownership record for outstanding loads; a set on the same tag as a clear wins.
module mem_arb_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  arb_owner_t       set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_valid,
  output arb_owner_t       lookup_owner
);

  // Entry 0 exists only to keep indexing simple; tag 0 is never recorded.
  logic [ARB_NUM_TAGS:0] valid_q;
  arb_owner_t            owner_q [ARB_NUM_TAGS+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_tag] <= 1'b0;
      if (set_en) valid_q[set_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (set_en) owner_q[set_tag] <= set_owner;
  end

  always_comb begin
    lookup_valid = 1'b0;
    lookup_owner = OWNER_ICACHE;
    if (lookup_tag != '0) begin
      lookup_valid = valid_q[lookup_tag];
      lookup_owner = owner_q[lookup_tag];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between icache and dcache and routes returning loads by tag.
// Define MEM_ARB_RR_EN for round-robin conflicts; otherwise the dcache always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic         arb_err
);

  localparam logic [TAG_W-1:0] MAX_CNT = TAG_W'(MAX_OUTSTANDING);

  logic [TAG_W-1:0] icnt, dcnt;
  logic             i_elig, d_elig, grant_i, grant_d, d_wins;
  logic             accepted, set_en, ret_valid, ret_hit, err_set;
  logic             inc_i, inc_d, dec_i, dec_d;
  arb_owner_t       grantee, ret_owner;

  function automatic logic [TAG_W-1:0] cnt_step(input logic [TAG_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [TAG_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)                 nxt = cnt + 1'b1;
    else if (dec && !inc && cnt != 0) nxt = cnt - 1'b1;
    return nxt;
  endfunction

`ifdef MEM_ARB_RR_EN
  arb_owner_t last_grant;

  // Resetting to dcache means the first conflict goes to the icache.
  always_ff @(posedge clock) begin
    if (reset)         last_grant <= OWNER_DCACHE;
    else if (accepted) last_grant <= grantee;
  end

  assign d_wins = (last_grant == OWNER_ICACHE);
`else
  assign d_wins = 1'b1;
`endif

  always_comb begin
    i_elig  = (bus.icache2arb_command != BUS_NONE) &&
              !((bus.icache2arb_command == BUS_LOAD) && (icnt == MAX_CNT));
    d_elig  = (bus.dcache2arb_command != BUS_NONE) &&
              !((bus.dcache2arb_command == BUS_LOAD) && (dcnt == MAX_CNT));
    grant_d = d_elig && (!i_elig || d_wins);
    grant_i = i_elig && !grant_d;
    grantee = grant_d ? OWNER_DCACHE : OWNER_ICACHE;
  end

  always_comb begin
    bus.arb2mem_command = BUS_NONE;
    bus.arb2mem_addr    = '0;
    bus.arb2mem_data    = '0;
    if (grant_d) begin
      bus.arb2mem_command = bus.dcache2arb_command;
      bus.arb2mem_addr    = bus.dcache2arb_addr;
      bus.arb2mem_data    = bus.dcache2arb_data;
    end else if (grant_i) begin
      bus.arb2mem_command = bus.icache2arb_command;
      bus.arb2mem_addr    = bus.icache2arb_addr;
    end
    bus.arb2icache_response = grant_i ? bus.mem2arb_response : '0;
    bus.arb2dcache_response = grant_d ? bus.mem2arb_response : '0;
  end

  assign accepted = (grant_i || grant_d) && (bus.mem2arb_response != '0);
  assign set_en   = accepted && (bus.arb2mem_command == BUS_LOAD);

  mem_arb_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (set_en),
    .set_tag      (bus.mem2arb_response),
    .set_owner    (grantee),
    .clr_en       (ret_hit),
    .clr_tag      (bus.mem2arb_tag),
    .lookup_tag   (bus.mem2arb_tag),
    .lookup_valid (ret_valid),
    .lookup_owner (ret_owner)
  );

  // Routing uses the owner recorded before this cycle's set lands.
  always_comb begin
    ret_hit = (bus.mem2arb_tag != '0) && ret_valid;
    err_set = (bus.mem2arb_tag != '0) && !ret_valid;
    bus.arb2icache_tag  = '0;
    bus.arb2icache_data = '0;
    bus.arb2dcache_tag  = '0;
    bus.arb2dcache_data = '0;
    if (ret_hit && ret_owner == OWNER_ICACHE) begin
      bus.arb2icache_tag  = bus.mem2arb_tag;
      bus.arb2icache_data = bus.mem2arb_data;
    end
    if (ret_hit && ret_owner == OWNER_DCACHE) begin
      bus.arb2dcache_tag  = bus.mem2arb_tag;
      bus.arb2dcache_data = bus.mem2arb_data;
    end
  end

  assign inc_i = set_en && (grantee == OWNER_ICACHE);
  assign inc_d = set_en && (grantee == OWNER_DCACHE);
  assign dec_i = ret_hit && (ret_owner == OWNER_ICACHE);
  assign dec_d = ret_hit && (ret_owner == OWNER_DCACHE);

  always_ff @(posedge clock) begin
    if (reset) begin
      icnt    <= '0;
      dcnt    <= '0;
      arb_err <= 1'b0;
    end else begin
      icnt <= cnt_step(icnt, inc_i, dec_i);
      dcnt <= cnt_step(dcnt, inc_d, dec_d);
      if (err_set) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a tag/count model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAX = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic arb_err;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .arb_err (arb_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: which cache owns each tag, per-cache load counts, sticky error, last winner.
  bit ref_valid [16];
  int ref_owner [16];
  int ref_cnt   [2];
  bit ref_err;
  int ref_last;

  logic [1:0]  exp_cmd;
  logic [63:0] exp_addr, exp_data, exp_idata, exp_ddata;
  logic [3:0]  exp_iresp, exp_dresp, exp_itag, exp_dtag;

  int         p_w, p_owner;
  logic [3:0] p_resp, p_tag;
  logic [1:0] p_cmd;
  bit         p_hit;

  task automatic model_reset();
    for (int t = 0; t < 16; t++) begin
      ref_valid[t] = 1'b0;
      ref_owner[t] = 0;
    end
    ref_cnt[0] = 0;
    ref_cnt[1] = 0;
    ref_err    = 1'b0;
    ref_last   = 1;
  endtask

  task automatic model_commit();
    if (p_hit) begin
      ref_valid[p_tag] = 1'b0;
      if (ref_cnt[p_owner] > 0) ref_cnt[p_owner]--;
    end
    if (p_tag != 0 && !p_hit) ref_err = 1'b1;
    if (p_w >= 0 && p_resp != 0) begin
      ref_last = p_w;
      if (p_cmd == BUS_LOAD) begin
        ref_valid[p_resp] = 1'b1;
        ref_owner[p_resp] = p_w;
        ref_cnt[p_w]++;
      end
    end
  endtask

  task automatic apply(input logic [1:0] icmd, input logic [63:0] iaddr,
                       input logic [1:0] dcmd, input logic [63:0] daddr, input logic [63:0] ddata,
                       input logic [3:0] resp, input logic [63:0] mdata, input logic [3:0] mtag);
    bit ie, de;
    bus.icache2arb_command = icmd;
    bus.icache2arb_addr    = iaddr;
    bus.dcache2arb_command = dcmd;
    bus.dcache2arb_addr    = daddr;
    bus.dcache2arb_data    = ddata;
    bus.mem2arb_response   = resp;
    bus.mem2arb_data       = mdata;
    bus.mem2arb_tag        = mtag;
    ie = (icmd != BUS_NONE) && !(icmd == BUS_LOAD && ref_cnt[0] == MAX);
    de = (dcmd != BUS_NONE) && !(dcmd == BUS_LOAD && ref_cnt[1] == MAX);
    if (ie && de) begin
`ifdef MEM_ARB_RR_EN
      p_w = 1 - ref_last;
`else
      p_w = 1;
`endif
    end else if (ie) p_w = 0;
    else if (de)     p_w = 1;
    else             p_w = -1;
    exp_cmd = BUS_NONE; exp_addr = '0; exp_data = '0;
    if (p_w == 0) begin exp_cmd = icmd; exp_addr = iaddr; end
    if (p_w == 1) begin exp_cmd = dcmd; exp_addr = daddr; exp_data = ddata; end
    exp_iresp = (p_w == 0) ? resp : 4'd0;
    exp_dresp = (p_w == 1) ? resp : 4'd0;
    p_resp  = resp;
    p_cmd   = exp_cmd;
    p_tag   = mtag;
    p_hit   = (mtag != 0) && ref_valid[mtag];
    p_owner = ref_owner[mtag];
    exp_itag  = (p_hit && p_owner == 0) ? mtag  : 4'd0;
    exp_idata = (p_hit && p_owner == 0) ? mdata : 64'd0;
    exp_dtag  = (p_hit && p_owner == 1) ? mtag  : 4'd0;
    exp_ddata = (p_hit && p_owner == 1) ? mdata : 64'd0;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else       model_commit();
    #1;
  endtask

  task automatic idle(input logic [63:0] mdata, input logic [3:0] mtag);
    apply(BUS_NONE, 64'd0, BUS_NONE, 64'd0, 64'd0, 4'd0, mdata, mtag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(64'd0, 4'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(64'd0, 4'd0);
    checks++;
    if ({bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data, bus.arb2icache_response,
         bus.arb2dcache_response, bus.arb2icache_tag, bus.arb2icache_data,
         bus.arb2dcache_tag, bus.arb2dcache_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cmd=%0d addr=%h data=%h ir=%0d dr=%0d required all zero",
               bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data,
               bus.arb2icache_response, bus.arb2dcache_response);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (arb_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b required 0", arb_err);
    end
  endtask

  task automatic test_icache_load();
    do_reset();
    apply(BUS_LOAD, 64'h100, BUS_NONE, 64'd0, 64'd0, 4'd3, 64'd0, 4'd0);
    checks++;
    if ({bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data} !== {BUS_LOAD, 64'h100, 64'd0}) begin
      errors++; $display("FAIL iload_mem got cmd=%0d addr=%h data=%h required 1 100 0",
                         bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data);
    end
    checks++;
    if ({bus.arb2icache_response, bus.arb2dcache_response} !== {4'd3, 4'd0}) begin
      errors++; $display("FAIL iload_resp got i=%0d d=%0d required i=3 d=0",
                         bus.arb2icache_response, bus.arb2dcache_response);
    end
    tick();
    idle(64'hDEAD, 4'd3);
    checks++;
    if ({bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag, bus.arb2dcache_data} !==
        {4'd3, 64'hDEAD, 4'd0, 64'd0}) begin
      errors++; $display("FAIL iload_return got itag=%0d idata=%h dtag=%0d ddata=%h required 3 dead 0 0",
                         bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag, bus.arb2dcache_data);
    end
    tick();
    checks++;
    if (arb_err !== 1'b0) begin
      errors++; $display("FAIL iload_err got %b required 0", arb_err);
    end
  endtask

  task automatic test_conflict();
    logic [3:0] rsp [3];
    bit         to_i [3];
    rsp[0] = 4'd5; rsp[1] = 4'd6; rsp[2] = 4'd9;
    do_reset();
    for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
      to_i[k] = (k != 1);
`else
      to_i[k] = 1'b0;
`endif
      apply(BUS_LOAD, 64'h1000 + 64'(k), BUS_LOAD, 64'h2000 + 64'(k), 64'hAA, rsp[k], 64'd0, 4'd0);
      checks++;
      if ({bus.arb2icache_response, bus.arb2dcache_response, bus.arb2mem_addr} !==
          {(to_i[k] ? rsp[k] : 4'd0), (to_i[k] ? 4'd0 : rsp[k]),
           (to_i[k] ? 64'h1000 : 64'h2000) + 64'(k)}) begin
        errors++; $display("FAIL conflict_grant%0d got i=%0d d=%0d addr=%h required icache_wins=%0d resp=%0d",
                           k, bus.arb2icache_response, bus.arb2dcache_response, bus.arb2mem_addr, to_i[k], rsp[k]);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle(64'hC0 + 64'(k), rsp[k]);
      checks++;
      if ({bus.arb2icache_tag, bus.arb2dcache_tag} !==
          {(to_i[k] ? rsp[k] : 4'd0), (to_i[k] ? 4'd0 : rsp[k])}) begin
        errors++; $display("FAIL conflict_return%0d got itag=%0d dtag=%0d required icache_owner=%0d tag=%0d",
                           k, bus.arb2icache_tag, bus.arb2dcache_tag, to_i[k], rsp[k]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    do_reset();
    apply(BUS_NONE, 64'd0, BUS_STORE, 64'h200, 64'h55, 4'd7, 64'd0, 4'd0);
    checks++;
    if ({bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data, bus.arb2dcache_response,
         bus.arb2icache_response} !== {BUS_STORE, 64'h200, 64'h55, 4'd7, 4'd0}) begin
      errors++; $display("FAIL store_mem got cmd=%0d addr=%h data=%h dr=%0d ir=%0d required 2 200 55 7 0",
                         bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data,
                         bus.arb2dcache_response, bus.arb2icache_response);
    end
    tick();
    idle(64'h77, 4'd7);
    checks++;
    if ({bus.arb2icache_tag, bus.arb2dcache_tag, bus.arb2icache_data, bus.arb2dcache_data} !== '0) begin
      errors++; $display("FAIL store_return got itag=%0d dtag=%0d required 0 0",
                         bus.arb2icache_tag, bus.arb2dcache_tag);
    end
    tick();
    checks++;
    if (arb_err !== 1'b1) begin
      errors++; $display("FAIL store_err got %b required 1", arb_err);
    end
  endtask

  task automatic test_max_outstanding();
    do_reset();
    for (int t = 1; t <= MAX; t++) begin
      apply(BUS_LOAD, 64'h300 + 64'(t), BUS_NONE, 64'd0, 64'd0, 4'(t), 64'd0, 4'd0);
      checks++;
      if (bus.arb2icache_response !== 4'(t)) begin
        errors++; $display("FAIL max_fill%0d got %0d required %0d", t, bus.arb2icache_response, t);
      end
      tick();
    end
    apply(BUS_LOAD, 64'h400, BUS_NONE, 64'd0, 64'd0, 4'd9, 64'd0, 4'd0);
    checks++;
    if ({bus.arb2mem_command, bus.arb2icache_response} !== {BUS_NONE, 4'd0}) begin
      errors++; $display("FAIL max_block got cmd=%0d ir=%0d required 0 0",
                         bus.arb2mem_command, bus.arb2icache_response);
    end
    tick();
    apply(BUS_LOAD, 64'h400, BUS_LOAD, 64'h500, 64'd0, 4'd9, 64'd0, 4'd0);
    checks++;
    if ({bus.arb2icache_response, bus.arb2dcache_response, bus.arb2mem_addr} !== {4'd0, 4'd9, 64'h500}) begin
      errors++; $display("FAIL max_dcache got ir=%0d dr=%0d addr=%h required 0 9 500",
                         bus.arb2icache_response, bus.arb2dcache_response, bus.arb2mem_addr);
    end
    tick();
    apply(BUS_LOAD, 64'h400, BUS_NONE, 64'd0, 64'd0, 4'd10, 64'h1, 4'd2);
    checks++;
    if ({bus.arb2icache_response, bus.arb2icache_tag} !== {4'd0, 4'd2}) begin
      errors++; $display("FAIL max_return got ir=%0d itag=%0d required 0 2",
                         bus.arb2icache_response, bus.arb2icache_tag);
    end
    tick();
    apply(BUS_LOAD, 64'h400, BUS_NONE, 64'd0, 64'd0, 4'd2, 64'd0, 4'd0);
    checks++;
    if ({bus.arb2mem_command, bus.arb2icache_response} !== {BUS_LOAD, 4'd2}) begin
      errors++; $display("FAIL max_reenable got cmd=%0d ir=%0d required 1 2",
                         bus.arb2mem_command, bus.arb2icache_response);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    apply(BUS_NONE, 64'd0, BUS_LOAD, 64'h600, 64'd0, 4'd4, 64'd0, 4'd0);
    checks++;
    if (bus.arb2dcache_response !== 4'd4) begin
      errors++; $display("FAIL same_setup got %0d required 4", bus.arb2dcache_response);
    end
    tick();
    apply(BUS_LOAD, 64'h700, BUS_NONE, 64'd0, 64'd0, 4'd4, 64'hBEEF, 4'd4);
    checks++;
    if ({bus.arb2icache_response, bus.arb2dcache_tag, bus.arb2dcache_data, bus.arb2icache_tag,
         bus.arb2icache_data} !== {4'd4, 4'd4, 64'hBEEF, 4'd0, 64'd0}) begin
      errors++; $display("FAIL same_route got ir=%0d dtag=%0d ddata=%h itag=%0d required 4 4 beef 0",
                         bus.arb2icache_response, bus.arb2dcache_tag, bus.arb2dcache_data, bus.arb2icache_tag);
    end
    tick();
    idle(64'h1234, 4'd4);
    checks++;
    if ({bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag} !== {4'd4, 64'h1234, 4'd0}) begin
      errors++; $display("FAIL same_newowner got itag=%0d idata=%h dtag=%0d required 4 1234 0",
                         bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag);
    end
    tick();
    checks++;
    if (arb_err !== 1'b0) begin
      errors++; $display("FAIL same_err got %b required 0", arb_err);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    apply(BUS_LOAD, 64'h10, BUS_NONE, 64'd0, 64'd0, 4'd1, 64'd0, 4'd0); tick();
    apply(BUS_NONE, 64'd0, BUS_LOAD, 64'h20, 64'd0, 4'd2, 64'd0, 4'd0); tick();
    apply(BUS_LOAD, 64'h30, BUS_LOAD, 64'h40, 64'd0, 4'd3, 64'd0, 4'd0); tick();
    do_reset();
    checks++;
    if (arb_err !== 1'b0) begin
      errors++; $display("FAIL mid_err_cleared got %b required 0", arb_err);
    end
    for (int t = 1; t <= 3; t++) begin
      idle(64'hF0 + 64'(t), 4'(t));
      checks++;
      if ({bus.arb2icache_tag, bus.arb2dcache_tag} !== 8'd0) begin
        errors++; $display("FAIL mid_stale%0d got itag=%0d dtag=%0d required 0 0",
                           t, bus.arb2icache_tag, bus.arb2dcache_tag);
      end
      tick();
    end
    checks++;
    if (arb_err !== 1'b1) begin
      errors++; $display("FAIL mid_err got %b required 1", arb_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [1:0] ic, dc;
      logic [3:0] rs, mt;
      int r, s, t;
      ic = ($urandom_range(0, 2) == 0) ? BUS_NONE : BUS_LOAD;
      r  = $urandom_range(0, 2);
      dc = (r == 0) ? BUS_NONE : (r == 1) ? BUS_LOAD : BUS_STORE;
      mt = 4'd0;
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(1, 15);
        for (int j = 0; j < 15; j++) begin
          t = 1 + ((s - 1 + j) % 15);
          if (mt == 0 && ref_valid[t]) mt = 4'(t);
        end
      end
      rs = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 4) == 0 || (ref_valid[rs] && rs != mt)) rs = 4'd0;
      apply(ic, {$urandom(), $urandom()}, dc, {$urandom(), $urandom()}, {$urandom(), $urandom()},
            rs, {$urandom(), $urandom()}, mt);
      checks++;
      if ({bus.arb2mem_command, bus.arb2mem_addr, bus.arb2mem_data} !== {exp_cmd, exp_addr, exp_data}) begin
        errors++; $display("FAIL rnd_mem%0d got %0d %h %h required %0d %h %h", c, bus.arb2mem_command,
                           bus.arb2mem_addr, bus.arb2mem_data, exp_cmd, exp_addr, exp_data);
      end
      checks++;
      if ({bus.arb2icache_response, bus.arb2dcache_response} !== {exp_iresp, exp_dresp}) begin
        errors++; $display("FAIL rnd_resp%0d got i=%0d d=%0d required i=%0d d=%0d", c,
                           bus.arb2icache_response, bus.arb2dcache_response, exp_iresp, exp_dresp);
      end
      checks++;
      if ({bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag, bus.arb2dcache_data} !==
          {exp_itag, exp_idata, exp_dtag, exp_ddata}) begin
        errors++; $display("FAIL rnd_ret%0d got itag=%0d dtag=%0d required itag=%0d dtag=%0d", c,
                           bus.arb2icache_tag, bus.arb2dcache_tag, exp_itag, exp_dtag);
      end
      tick();
      checks++;
      if (arb_err !== ref_err) begin
        errors++; $display("FAIL rnd_err%0d got %b required %b", c, arb_err, ref_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_icache_load();
    test_conflict();
    test_store();
    test_max_outstanding();
    test_same_cycle();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
